// File: rtl/vmem_pkg.sv
// rtl/vmem_pkg.sv - shared types and constants for the vector data memory arbiter
package vmem_pkg;
  localparam int VMEM_LANES  = 6;
  localparam int VMEM_LANE_W = 8;
  localparam int VMEM_DEPTH  = 102;

  typedef logic [VMEM_LANES-1:0][VMEM_LANE_W-1:0] vword_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;
endpackage

// File: rtl/vmem_arbiter_rr_pick.sv
// rtl/vmem_arbiter_rr_pick.sv - combinational round-robin picker
// First asserted request at or above ptr wins, wrapping modulo N.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int k;
    k     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // Walk from the farthest offset down so the nearest one to ptr overwrites last.
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N;
      if (req[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
        idx      = IW'(k);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vmem_arbiter.sv
// rtl/vmem_arbiter.sv - round-robin arbiter with locked bursts in front of the vector data memory
// Optional address bounds check: VMEM_ARB_BOUNDS_CHECK_EN.
module vmem_arbiter
  import vmem_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int LANES     = VMEM_LANES,
  parameter int LANE_W    = VMEM_LANE_W,
  parameter int DEPTH     = VMEM_DEPTH,
  parameter int MAX_BURST = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ-1:0]              req_we,
  input  logic [N_REQ-1:0]              req_lock,
  input  logic [N_REQ*32-1:0]           req_addr,
  input  logic [N_REQ*LANES*LANE_W-1:0] req_wdata,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [LANES*LANE_W-1:0]       rsp_rdata,
  output logic                          mem_we,
  output logic [31:0]                   mem_a,
  output logic [LANES*LANE_W-1:0]       mem_wd,
  input  logic [LANES*LANE_W-1:0]       mem_rd,
  output logic                          err_oob
);

  localparam int W  = LANES * LANE_W;
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t       state, state_n;
  logic [IW-1:0]    rr_ptr, rr_ptr_n, owner, owner_n, win, pick_idx;
  logic [CW-1:0]    beat_cnt, beat_cnt_n;
  logic [N_REQ-1:0] pick_grant, grant;
  logic             pick_any, win_any, sel_we, sel_lock, oob;
  logic [31:0]      sel_addr;
  logic [W-1:0]     sel_wdata;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] i);
    return (i == IW'(N_REQ - 1)) ? '0 : i + IW'(1);
  endfunction

  // In a burst only the owner may be granted; reset masks every grant immediately.
  always_comb begin
    win     = pick_idx;
    win_any = pick_any;
    grant   = pick_grant;
    if (state == BURST) begin
      win     = owner;
      win_any = req_valid[owner];
      grant   = N_REQ'(1) << owner;
    end
    if (!win_any || !rst_n) begin
      win_any = 1'b0;
      grant   = '0;
    end
  end

  assign sel_addr  = req_addr[32*int'(win) +: 32];
  assign sel_wdata = req_wdata[W*int'(win) +: W];
  assign sel_we    = req_we[win];
  assign sel_lock  = req_lock[win];

`ifdef VMEM_ARB_BOUNDS_CHECK_EN
  assign oob = 32'(sel_addr[13:2]) >= 32'(DEPTH);
`else
  assign oob = 1'b0;
`endif

  assign req_ready = grant;
  assign mem_a     = win_any ? sel_addr : '0;
  assign mem_wd    = win_any ? sel_wdata : '0;
  assign mem_we    = win_any & sel_we & ~oob;

  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    owner_n    = owner;
    beat_cnt_n = beat_cnt;
    if (win_any) begin
      if (state == IDLE) begin
        rr_ptr_n = ptr_after(win);
        if (sel_lock && MAX_BURST > 1) begin
          state_n    = BURST;
          owner_n    = win;
          beat_cnt_n = CW'(1);
        end
      end else if (!sel_lock || (beat_cnt + CW'(1)) >= CW'(MAX_BURST)) begin
        // Leaving a burst (voluntarily or by watchdog) hands the next slot past the owner.
        state_n    = IDLE;
        rr_ptr_n   = ptr_after(owner);
        beat_cnt_n = '0;
      end else begin
        beat_cnt_n = beat_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      beat_cnt  <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      owner     <= owner_n;
      beat_cnt  <= beat_cnt_n;
      rsp_valid <= (win_any && !sel_we) ? grant : '0;
      if (win_any && !sel_we) rsp_rdata <= oob ? '0 : mem_rd;
    end
  end

`ifdef VMEM_ARB_BOUNDS_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_oob <= 1'b0;
    else if (win_any && oob) err_oob <= 1'b1;
  end
`else
  assign err_oob = 1'b0;
`endif

endmodule

// File: tb/tb_vmem_arbiter.sv
// tb/tb_vmem_arbiter.sv - directed scoreboard bench for vmem_arbiter (MAX_BURST=4)
module tb_vmem_arbiter;
  import vmem_pkg::*;

  localparam int W = VMEM_LANES * VMEM_LANE_W;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [31:0]    addr [2];
  logic [W-1:0]   wdata [2];
  logic [63:0]    req_addr;
  logic [2*W-1:0] req_wdata;
  logic [W-1:0]   rsp_rdata, mem_wd, mem_rd;
  logic [31:0]    mem_a;
  logic           mem_we, err_oob;

  logic [W-1:0]   mem [4096];
  logic [W-1:0]   ref_mem [4096];

  typedef struct {
    int           req;
    logic [W-1:0] data;
  } rsp_t;
  rsp_t sb[$];

  int checks = 0;
  int errors = 0;

  assign req_addr  = {addr[1], addr[0]};
  assign req_wdata = {wdata[1], wdata[0]};
  assign mem_rd    = mem[mem_a[13:2]];

  always #5 clk = ~clk;

  vmem_arbiter #(.N_REQ(2), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_we    (mem_we),
    .mem_a     (mem_a),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd),
    .err_oob   (err_oob)
  );

  function automatic logic [W-1:0] pat(input int i);
    return {8'hA0, 8'(i), 8'h5C, 8'(i >> 8), 8'hE1, 8'(i)};
  endfunction

  // Memory environment: combinational read, write on the rising edge.
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = pat(i);
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_a[13:2]] <= mem_wd;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int r, input logic v, input logic we, input logic lk,
                       input logic [31:0] a, input logic [W-1:0] d);
    req_valid[r] = v;
    req_we[r]    = we;
    req_lock[r]  = lk;
    addr[r]      = a;
    wdata[r]     = d;
  endtask

  // One beat: w is the requester expected to be granted, -1 for none.
  task automatic cycle(input int w);
    logic [1:0] exp_ready;
    int         idx;
    logic       oob;
    rsp_t       e;
    #1;
    exp_ready = (w < 0) ? 2'b00 : (2'b01 << w);
    chk("ready", req_ready, exp_ready);
    if (w >= 0) begin
      idx = int'(addr[w][13:2]);
      oob = 1'b0;
`ifdef VMEM_ARB_BOUNDS_CHECK_EN
      oob = (idx >= VMEM_DEPTH);
`endif
      chk("mem_a", mem_a, addr[w]);
      chk("mem_we", mem_we, req_we[w] & ~oob);
      if (req_we[w]) begin
        chk("mem_wd", mem_wd, wdata[w]);
        if (!oob) ref_mem[idx] = wdata[w];
      end else begin
        sb.push_back('{w, oob ? '0 : ref_mem[idx]});
      end
    end else begin
      chk("mem_we_idle", mem_we, 1'b0);
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rsp_valid", rsp_valid, 2'b01 << e.req);
      chk("rsp_rdata", rsp_rdata, e.data);
    end else begin
      chk("rsp_none", rsp_valid, 2'b00);
    end
    @(negedge clk);
  endtask

  initial begin
    logic exp_oob;
    exp_oob = 1'b0;
`ifdef VMEM_ARB_BOUNDS_CHECK_EN
    exp_oob = 1'b1;
`endif
    for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_lock = '0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;

    // Reset state with a request pending
    drive(0, 1'b1, 1'b0, 1'b0, 32'h8, '0);
    #12;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_rdata", rsp_rdata, '0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wd", mem_wd, '0);
    chk("rst_err_oob", err_oob, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single read of word 2
    cycle(0);
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, '0);
    cycle(-1);

    // Contention, rr_ptr sits at 1 after the single read
    drive(0, 1'b1, 1'b0, 1'b0, 32'h20, '0);
    drive(1, 1'b1, 1'b0, 1'b0, 32'h40, '0);
    cycle(1); cycle(0); cycle(1); cycle(0);

    // Locked burst by req1, owner idles once mid-burst
    drive(1, 1'b1, 1'b0, 1'b1, 32'h30, '0);
    cycle(1);
    drive(1, 1'b0, 1'b0, 1'b1, 32'h30, '0);
    cycle(-1);
    drive(1, 1'b1, 1'b0, 1'b1, 32'h34, '0);
    cycle(1);
    drive(1, 1'b1, 1'b0, 1'b0, 32'h38, '0);
    cycle(1);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, '0);
    cycle(0);

    // Watchdog: req0 write burst with lock held, released after beat 4
    drive(0, 1'b1, 1'b1, 1'b1, 32'h100, {16'($urandom), $urandom});
    cycle(0);
    drive(1, 1'b1, 1'b0, 1'b0, 32'h50, '0);
    for (int k = 1; k < 3; k++) begin
      drive(0, 1'b1, 1'b1, 1'b1, 32'h100 + 32'(4*k), {16'($urandom), $urandom});
      cycle(0);
    end
    drive(0, 1'b0, 1'b1, 1'b1, 32'h10C, '0);
    cycle(-1);
    drive(0, 1'b1, 1'b1, 1'b1, 32'h10C, {16'($urandom), $urandom});
    cycle(0);
    drive(0, 1'b1, 1'b1, 1'b1, 32'h110, {16'($urandom), $urandom});
    cycle(1);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, '0);
    cycle(0);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h114, {16'($urandom), $urandom});
    cycle(0);

    // Write then read, read-after-write on consecutive beats, top valid index
    drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 48'h06_05_04_03_02_01);
    cycle(0);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h10, '0);
    cycle(0);
    chk("wr_rd_word", rsp_rdata, 48'h06_05_04_03_02_01);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h104, '0);
    cycle(0);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h194, 48'hAB_CD_EF_01_23_45);
    cycle(0);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h194, '0);
    cycle(0);
    chk("err_oob_in_range", err_oob, 1'b0);
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, '0);

    // Async reset in the middle of a burst with a response pending
    drive(1, 1'b1, 1'b0, 1'b1, 32'h44, '0);
    #1;
    chk("pre_rst_ready", req_ready, 2'b10);
    @(posedge clk);
    #1;
    chk("pre_rst_rsp", rsp_valid, 2'b10);
    chk("pre_rst_data", rsp_rdata, ref_mem[17]);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 2'b00);
    chk("mid_rst_rsp_rdata", rsp_rdata, '0);
    chk("mid_rst_ready", req_ready, 2'b00);
    chk("mid_rst_mem_a", mem_a, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b0, 1'b0, 32'h48, '0);
    drive(1, 1'b1, 1'b0, 1'b0, 32'h44, '0);
    cycle(0);
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, '0);
    cycle(1);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, '0);

    // Out-of-range index 102
    drive(0, 1'b1, 1'b1, 1'b0, 32'h198, 48'h11_22_33_44_55_66);
    cycle(0);
    chk("err_oob_set", err_oob, exp_oob);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h198, '0);
    cycle(0);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h8, '0);
    cycle(0);
    chk("err_oob_sticky", err_oob, exp_oob);
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, '0);
    cycle(-1);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
